fifo_ctrl: RTL and testbench

//  Write/read control for the FIFO memory bank. Turns upstream push/pop requests into
//  the push, pop, wr_ptr and rd_ptr signals the memory consumes.

---
 rtl/fifo_ctrl.sv | 112 +++++++++++
 tb/tb_fifo_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: write/read pointer and strobe control for a MEM_SIZE-entry FIFO memory bank.
// Tracks occupancy, decodes full/empty/almost flags and reports rejected requests.
// Optional feature macro: ERR_STICKY_EN (defined -> error flags latch until reset,
// undefined -> error flags are one-cycle registered pulses).
module fifo_ctrl #(
  parameter int MEM_SIZE = 4,
  parameter int PTR_L    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_req,
  input  logic             pop_req,
  input  logic [PTR_L-1:0] almost_full_thr,
  input  logic [PTR_L-1:0] almost_empty_thr,
  output logic             push,
  output logic             pop,
  output logic [PTR_L-1:0] wr_ptr,
  output logic [PTR_L-1:0] rd_ptr,
  output logic [PTR_L-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             data_valid,
  output logic             overflow_err,
  output logic             underflow_err
);

  localparam logic [PTR_L-1:0] MemSizeC = PTR_L'(MEM_SIZE);
  localparam logic [PTR_L-1:0] LastIdxC = PTR_L'(MEM_SIZE - 1);
  localparam logic [PTR_L-1:0] OneC     = PTR_L'(1);

  logic [PTR_L-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_L-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_L-1:0] count_q, count_d;
  logic             dataValid_q;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             isFull, isEmpty, pushOk, popOk;

  // Status flags and accept strobes decode straight from the registered count, so a
  // request is judged against the occupancy held before the coming edge.
  always_comb begin
    isFull  = (count_q == MemSizeC);
    isEmpty = (count_q == '0);
    pushOk  = push_req & ~isFull & ~reset;
    popOk   = pop_req & ~isEmpty & ~reset;
  end

  // Next pointer, occupancy and error state; both pointers wrap at the last entry and
  // a simultaneous accepted push and pop leave the occupancy unchanged.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (pushOk) begin
      wrPtr_d = (wrPtr_q == LastIdxC) ? '0 : wrPtr_q + OneC;
    end
    if (popOk) begin
      rdPtr_d = (rdPtr_q == LastIdxC) ? '0 : rdPtr_q + OneC;
    end
    case ({pushOk, popOk})
      2'b10:   count_d = count_q + OneC;
      2'b01:   count_d = count_q - OneC;
      default: count_d = count_q;
    endcase
`ifdef ERR_STICKY_EN
    overflow_d  = overflow_q | (push_req & isFull);
    underflow_d = underflow_q | (pop_req & isEmpty);
`else
    overflow_d  = push_req & isFull;
    underflow_d = pop_req & isEmpty;
`endif
  end

  // State registers; reset wins over any request and discards the FIFO contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      dataValid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      dataValid_q <= popOk;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Output mapping; thresholds are compared live, so a threshold above MEM_SIZE simply
  // keeps almost_full low.
  always_comb begin
    push          = pushOk;
    pop           = popOk;
    wr_ptr        = wrPtr_q;
    rd_ptr        = rdPtr_q;
    count         = count_q;
    full          = isFull;
    empty         = isEmpty;
    almost_full   = (count_q >= almost_full_thr);
    almost_empty  = (count_q <= almost_empty_thr);
    data_valid    = dataValid_q;
    overflow_err  = overflow_q;
    underflow_err = underflow_q;
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed bench for fifo_ctrl with a companion memory, a queue-based
// reference model checked every cycle, and literal expectations at key points.
module tb_fifo_ctrl;

  localparam int MEM_SIZE  = 4;
  localparam int WORD_SIZE = 6;
  localparam int PTR_L     = 3;

  logic clk;
  logic resetIn, pushReq, popReq;
  logic [PTR_L-1:0] afThr, aeThr;
  logic [WORD_SIZE-1:0] dataIn;
  logic push, pop, full, empty, almostFull, almostEmpty, dataValid, ovfErr, unfErr;
  logic [PTR_L-1:0] wrPtr, rdPtr, count;

  int nCompared;
  int nMismatched;

  fifo_ctrl #(.MEM_SIZE(MEM_SIZE), .PTR_L(PTR_L)) dut (
    .clk             (clk),
    .reset           (resetIn),
    .push_req        (pushReq),
    .pop_req         (popReq),
    .almost_full_thr (afThr),
    .almost_empty_thr(aeThr),
    .push            (push),
    .pop             (pop),
    .wr_ptr          (wrPtr),
    .rd_ptr          (rdPtr),
    .count           (count),
    .full            (full),
    .empty           (empty),
    .almost_full     (almostFull),
    .almost_empty    (almostEmpty),
    .data_valid      (dataValid),
    .overflow_err    (ovfErr),
    .underflow_err   (unfErr)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Companion memory driven by the DUT strobes and addresses, one-cycle read latency.
  logic [WORD_SIZE-1:0] memArr [MEM_SIZE];
  logic [WORD_SIZE-1:0] dataOutMM;
  always @(posedge clk) begin
    if (push) memArr[wrPtr] <= dataIn;
    if (pop)  dataOutMM <= memArr[rdPtr];
  end

  // Reference model: contents as a queue, pointers as integers modulo MEM_SIZE.
  logic [WORD_SIZE-1:0] mQ[$];
  int   mWr, mRd;
  logic mDv, mOvf, mUnf, mValid;
  logic [WORD_SIZE-1:0] mExpData;

  initial begin
    mValid = 1'b0;
  end

  function automatic logic mAcceptPush();
    return pushReq && !resetIn && (mQ.size() < MEM_SIZE);
  endfunction

  function automatic logic mAcceptPop();
    return popReq && !resetIn && (mQ.size() > 0);
  endfunction

  // Advance the model on each rising edge using the inputs held across that edge.
  always @(posedge clk) begin
    logic doPush, doPop, wasFull, wasEmpty;
    doPush   = mAcceptPush();
    doPop    = mAcceptPop();
    wasFull  = (mQ.size() == MEM_SIZE);
    wasEmpty = (mQ.size() == 0);
    if (resetIn) begin
      mQ.delete();
      mWr = 0; mRd = 0; mDv = 1'b0; mOvf = 1'b0; mUnf = 1'b0;
      mValid = 1'b1;
    end else if (mValid) begin
      if (doPop) begin
        mExpData = mQ.pop_front();
        mRd = (mRd + 1) % MEM_SIZE;
      end
      if (doPush) begin
        mQ.push_back(dataIn);
        mWr = (mWr + 1) % MEM_SIZE;
      end
      mDv = doPop;
`ifdef ERR_STICKY_EN
      mOvf = mOvf || (pushReq && wasFull);
      mUnf = mUnf || (popReq && wasEmpty);
`else
      mOvf = pushReq && wasFull;
      mUnf = popReq && wasEmpty;
`endif
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    if (mValid) begin
      checkOutput("m_push", int'(push), int'(mAcceptPush()));
      checkOutput("m_pop", int'(pop), int'(mAcceptPop()));
      checkOutput("m_wr_ptr", int'(wrPtr), mWr);
      checkOutput("m_rd_ptr", int'(rdPtr), mRd);
      checkOutput("m_count", int'(count), mQ.size());
      checkOutput("m_count_range", int'(count <= PTR_L'(MEM_SIZE)), 1);
      checkOutput("m_full", int'(full), int'(mQ.size() == MEM_SIZE));
      checkOutput("m_empty", int'(empty), int'(mQ.size() == 0));
      checkOutput("m_almost_full", int'(almostFull), int'(mQ.size() >= int'(afThr)));
      checkOutput("m_almost_empty", int'(almostEmpty), int'(mQ.size() <= int'(aeThr)));
      checkOutput("m_data_valid", int'(dataValid), int'(mDv));
      checkOutput("m_overflow", int'(ovfErr), int'(mOvf));
      checkOutput("m_underflow", int'(unfErr), int'(mUnf));
      if (mDv) checkOutput("m_data_out", int'(dataOutMM), int'(mExpData));
    end
  end

  // Drive one cycle of inputs and return 1 time unit after the consuming edge.
  task automatic applyStimulus(input logic pr, input logic pp, input int d, input logic rst);
    pushReq = pr;
    popReq  = pp;
    dataIn  = WORD_SIZE'(d);
    resetIn = rst;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int expWr[4];
    int expRd[4];
    nCompared = 0;
    nMismatched = 0;
    afThr = 3'd3;
    aeThr = 3'd1;
    expWr = '{1, 2, 3, 0};
    expRd = '{1, 2, 3, 0};

    // Reset held for two cycles with push_req asserted.
    applyStimulus(1'b1, 1'b0, 9, 1'b1);
    applyStimulus(1'b1, 1'b0, 9, 1'b1);
    checkOutput("rst_push", int'(push), 0);
    checkOutput("rst_wr_ptr", int'(wrPtr), 0);
    checkOutput("rst_rd_ptr", int'(rdPtr), 0);
    checkOutput("rst_count", int'(count), 0);
    checkOutput("rst_empty", int'(empty), 1);
    checkOutput("rst_almost_empty", int'(almostEmpty), 1);
    checkOutput("rst_data_valid", int'(dataValid), 0);

    // Fill with 0x01..0x04.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, i + 1, 1'b0);
      checkOutput("fill_wr_ptr", int'(wrPtr), expWr[i]);
      if (i == 2) checkOutput("fill_almost_full_at3", int'(almostFull), 1);
    end
    checkOutput("fill_count", int'(count), 4);
    checkOutput("fill_full", int'(full), 1);
    pushReq = 1'b1;
    #1;
    checkOutput("ovf_push_blocked", int'(push), 0);
    applyStimulus(1'b1, 1'b0, 5, 1'b0);
    checkOutput("ovf_err", int'(ovfErr), 1);
    checkOutput("ovf_count", int'(count), 4);

    // Drain four entries, then one pop too many.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 0, 1'b0);
      checkOutput("drain_rd_ptr", int'(rdPtr), expRd[i]);
      checkOutput("drain_data_valid", int'(dataValid), 1);
      checkOutput("drain_data", int'(dataOutMM), i + 1);
    end
    checkOutput("drain_empty", int'(empty), 1);
    popReq = 1'b1;
    #1;
    checkOutput("unf_pop_blocked", int'(pop), 0);
    applyStimulus(1'b0, 1'b1, 0, 1'b0);
    checkOutput("unf_err", int'(unfErr), 1);
    checkOutput("unf_data_valid", int'(dataValid), 0);

    // Simultaneous requests at count 2: occupancy holds, both pointers move by 3.
    applyStimulus(1'b1, 1'b0, 5, 1'b0);
    applyStimulus(1'b1, 1'b0, 6, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 7 + i, 1'b0);
    checkOutput("both_count", int'(count), 2);
    checkOutput("both_rd_ptr", int'(rdPtr), 3);
    checkOutput("both_wr_ptr", int'(wrPtr), 1);

    // Simultaneous requests at full: first cycle pops only, then both accepted.
    applyStimulus(1'b1, 1'b0, 10, 1'b0);
    applyStimulus(1'b1, 1'b0, 11, 1'b0);
    checkOutput("both_full", int'(full), 1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 12 + i, 1'b0);
    checkOutput("both_full_count", int'(count), 3);

    // Reset in mid-operation at count 3.
    applyStimulus(1'b0, 1'b1, 0, 1'b1);
    checkOutput("midrst_count", int'(count), 0);
    checkOutput("midrst_wr_ptr", int'(wrPtr), 0);
    checkOutput("midrst_rd_ptr", int'(rdPtr), 0);
    checkOutput("midrst_empty", int'(empty), 1);
    checkOutput("midrst_ovf", int'(ovfErr), 0);
    checkOutput("midrst_unf", int'(unfErr), 0);

    // Overflow followed by three idle cycles.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 20 + i, 1'b0);
    applyStimulus(1'b1, 1'b0, 30, 1'b0);
    checkOutput("err6_set", int'(ovfErr), 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 0, 1'b0);
`ifdef ERR_STICKY_EN
      checkOutput("err6_idle", int'(ovfErr), 1);
`else
      checkOutput("err6_idle", int'(ovfErr), 0);
`endif
    end

    // Live thresholds: above MEM_SIZE never asserts almost_full; zero always does.
    afThr = 3'd7;
    #1;
    checkOutput("thr_high_af", int'(almostFull), 0);
    aeThr = 3'd4;
    #1;
    checkOutput("thr_ae_at4", int'(almostEmpty), 1);
    applyStimulus(1'b0, 1'b0, 0, 1'b1);
    afThr = 3'd0;
    #1;
    checkOutput("thr_zero_af", int'(almostFull), 1);
    aeThr = 3'd1;
    applyStimulus(1'b0, 1'b0, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
